// File: rtl/coord_pkg.sv
// Shared definitions for the writable element-coordinate table and its loader.
package coord_pkg;

  localparam int COORD_WIDTH_DEF = 16;

  // Beat layout: z in the low field, x directly above it.
  localparam int BEAT_Z_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } load_state_t;

  function automatic int beat_x_lsb(input int coord_width);
    return BEAT_Z_LSB + coord_width;
  endfunction

endpackage

// File: rtl/coord_table_rf.sv
// Coordinate register file: async-reset clear, one synchronous write port,
// one combinational read port. Out-of-range read addresses return zero.
module coord_table_rf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  // Decoded mux rather than direct indexing so unmapped addresses fall to zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem_reg[i];
    end
  end

endmodule

// File: rtl/coord_ram_loader.sv
// Streams per-channel (x, z) pairs into a writable coordinate table and serves
// zero-latency reads. Optional trailing checksum beat: COORD_LOAD_CHECKSUM_EN.
module coord_ram_loader
  import coord_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = $clog2(NUM_CHANNELS),
  parameter int COORD_WIDTH  = COORD_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [2*COORD_WIDTH-1:0] s_data,
  output logic                     busy,
  output logic                     done,
  output logic                     table_valid,
  output logic                     load_err,
  input  logic [DATA_WIDTH-1:0]    addr,
  output logic [COORD_WIDTH-1:0]   x_out,
  output logic [COORD_WIDTH-1:0]   z_out
);

  localparam int X_LSB = beat_x_lsb(COORD_WIDTH);

  load_state_t           state_reg, state_next;
  logic [DATA_WIDTH-1:0] idx_reg, idx_next;
  logic                  table_valid_reg, table_valid_next;
  logic                  done_reg, done_next;
  logic                  wr_en;
  logic                  last_beat;
  logic [COORD_WIDTH-1:0] beat_x, beat_z;
  logic [2*COORD_WIDTH-1:0] rd_word;
`ifdef COORD_LOAD_CHECKSUM_EN
  logic [COORD_WIDTH-1:0] sum_reg, sum_next;
  logic                   load_err_reg, load_err_next;
`endif

  assign beat_x    = s_data[X_LSB +: COORD_WIDTH];
  assign beat_z    = s_data[BEAT_Z_LSB +: COORD_WIDTH];
  assign last_beat = (idx_reg == DATA_WIDTH'(NUM_CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      table_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
`ifdef COORD_LOAD_CHECKSUM_EN
      sum_reg         <= '0;
      load_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      table_valid_reg <= table_valid_next;
      done_reg        <= done_next;
`ifdef COORD_LOAD_CHECKSUM_EN
      sum_reg         <= sum_next;
      load_err_reg    <= load_err_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    table_valid_next = table_valid_reg;
    done_next        = 1'b0;
    wr_en            = 1'b0;
    s_ready          = 1'b0;
`ifdef COORD_LOAD_CHECKSUM_EN
    sum_next         = sum_reg;
    load_err_next    = load_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        // start outranks abort here; abort has nothing to cancel.
        if (start) begin
          state_next       = ST_LOAD;
          idx_next         = '0;
          table_valid_next = 1'b0;
`ifdef COORD_LOAD_CHECKSUM_EN
          sum_next         = '0;
          load_err_next    = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else if (s_valid) begin
          wr_en = 1'b1;
`ifdef COORD_LOAD_CHECKSUM_EN
          sum_next = sum_reg + beat_x + beat_z;
`endif
          if (last_beat) begin
            idx_next = '0;
`ifdef COORD_LOAD_CHECKSUM_EN
            state_next = ST_CHECK;
`else
            state_next       = ST_IDLE;
            done_next        = 1'b1;
            table_valid_next = 1'b1;
`endif
          end else begin
            idx_next = idx_reg + DATA_WIDTH'(1);
          end
        end
      end
`ifdef COORD_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        s_ready = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (s_valid) begin
          state_next       = ST_IDLE;
          done_next        = 1'b1;
          table_valid_next = (beat_z == sum_reg);
          load_err_next    = (beat_z != sum_reg);
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign table_valid = table_valid_reg;
`ifdef COORD_LOAD_CHECKSUM_EN
  assign load_err    = load_err_reg;
`else
  assign load_err    = 1'b0;
`endif

  coord_table_rf #(
    .DEPTH (NUM_CHANNELS),
    .AW    (DATA_WIDTH),
    .WIDTH (2*COORD_WIDTH)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (idx_reg),
    .wdata ({beat_x, beat_z}),
    .raddr (addr),
    .rdata (rd_word)
  );

  assign x_out = rd_word[X_LSB +: COORD_WIDTH];
  assign z_out = rd_word[BEAT_Z_LSB +: COORD_WIDTH];

endmodule

// File: tb/tb_coord_ram_loader.sv
// Directed bench for coord_ram_loader; optional checksum section follows
// COORD_LOAD_CHECKSUM_EN.
module tb_coord_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        busy;
  logic        done;
  logic        table_valid;
  logic        load_err;
  logic [3:0]  addr = '0;
  logic [15:0] x_out;
  logic [15:0] z_out;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int ready_cnt = 0;

  coord_ram_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .load_err    (load_err),
    .addr        (addr),
    .x_out       (x_out),
    .z_out       (z_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (s_ready === 1'b1) ready_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_entries(input string tag, input logic [15:0] bx, input logic [15:0] bz);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), {x_out, z_out}, {bx + 16'(i), bz + 16'(i)});
    end
  endtask

  // Full load with s_valid held high; optional simultaneous abort on start.
  task automatic load_full(input logic [15:0] bx, input logic [15:0] bz, input logic with_abort);
    logic [15:0] sum;
    int d0;
    d0  = done_cnt;
    sum = '0;
    start = 1'b1;
    abort = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = {bx + 16'(i), bz + 16'(i)};
      sum     = sum + bx + bz + 16'(2*i);
      step();
    end
    s_valid = 1'b0;
`ifdef COORD_LOAD_CHECKSUM_EN
    s_valid = 1'b1;
    s_data  = {16'h0, sum};
    step();
    s_valid = 1'b0;
`endif
    check("load_done", {30'd0, done, busy}, 32'd2);
    check("load_tv", {31'd0, table_valid}, 32'd1);
    step();
    check("load_done_width", {31'd0, done}, 32'd0);
    check("load_done_cnt", 32'(done_cnt - d0), 32'd1);
    $display("load x0=%h z0=%h done table_valid=%0d", bx, bz, table_valid);
  endtask

  initial begin
    int d0, r0, k, budget;
    logic [15:0] sum;

    // Reset state
    #12;
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_tv", {31'd0, table_valid}, 32'd0);
    check("rst_status", {29'd0, busy, done, load_err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("rst_rd[%0d]", i), {x_out, z_out}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("idle_ready", {31'd0, s_ready}, 32'd0);

    // First full load, counting ready cycles
    r0 = ready_cnt;
    load_full(16'h000B, 16'h0100, 1'b0);
`ifdef COORD_LOAD_CHECKSUM_EN
    check("ready_cycles", 32'(ready_cnt - r0), 32'd17);
`else
    check("ready_cycles", 32'(ready_cnt - r0), 32'd16);
`endif
    addr = 4'd3;
    #1;
    check("rd3_x", {16'd0, x_out}, 32'h000E);
    check("rd3_z", {16'd0, z_out}, 32'h0103);

    // Gapped stream with a second start mid-load
    d0 = done_cnt;
    sum = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    budget = 0;
    while (k < 16 && budget < 100) begin
      s_valid = (budget % 2 == 0);
      start   = (budget == 5);
      s_data  = {16'h0200 + 16'(k), 16'h0300 + 16'(k)};
      #1;
      if (s_valid && s_ready) begin
        sum = sum + 16'h0500 + 16'(2*k);
        k++;
      end
      step();
      budget++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    check("gap_budget", 32'(k), 32'd16);
`ifdef COORD_LOAD_CHECKSUM_EN
    s_valid = 1'b1;
    s_data  = {16'h0, sum};
    step();
    s_valid = 1'b0;
`endif
    step();
    step();
    check("gap_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("gap_tv", {31'd0, table_valid}, 32'd1);
    check_entries("gap", 16'h0200, 16'h0300);
    $display("gapped load with mid-load start, dones=%0d", done_cnt - d0);

    // Abort coincident with beat 5
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = {16'h0400 + 16'(i), 16'h0500 + 16'(i)};
      abort   = (i == 4);
      step();
    end
    s_valid = 1'b0;
    abort = 1'b0;
    check("abort_idle", {30'd0, busy, s_ready}, 32'd0);
    check("abort_tv", {31'd0, table_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("abort_rd[%0d]", i), {x_out, z_out}, {16'h0400 + 16'(i), 16'h0500 + 16'(i)});
    end
    addr = 4'd4;
    #1;
    check("abort_rd4_old", {x_out, z_out}, 32'h0204_0304);
    step();
    step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    $display("aborted load after 4 writes, table_valid=%0d", table_valid);

    // Recovery load, with start and abort together in IDLE
    load_full(16'h000B, 16'h0100, 1'b1);
    check_entries("recov", 16'h000B, 16'h0100);

`ifdef COORD_LOAD_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        s_valid = 1'b1;
        s_data  = 32'h0001_0001;
        step();
      end
      check("cs_ready", {31'd0, s_ready}, 32'd1);
      s_data = (pass == 0) ? 32'h0000_0020 : 32'h0000_0021;
      step();
      s_valid = 1'b0;
      check("cs_done", {31'd0, done}, 32'd1);
      check("cs_tv", {31'd0, table_valid}, (pass == 0) ? 32'd1 : 32'd0);
      check("cs_err", {31'd0, load_err}, (pass == 0) ? 32'd0 : 32'd1);
      step();
      check("cs_done_cnt", 32'(done_cnt - d0), 32'd1);
      $display("checksum load pass=%0d load_err=%0d", pass, load_err);
    end
    check("cs_err_sticky", {31'd0, load_err}, 32'd1);
`endif

    // Asynchronous reset in the middle of a load
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = {16'h0600 + 16'(i), 16'h0700 + 16'(i)};
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_status", {28'd0, s_ready, busy, done, load_err}, 32'd0);
    check("arst_tv", {31'd0, table_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("arst_rd[%0d]", i), {x_out, z_out}, 32'd0);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_idle", {30'd0, s_ready, busy}, 32'd0);
    $display("async reset mid-load, table cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
